cal_seq_ctrl: RTL and testbench
===============================

Name: cal_seq_ctrl

Overview:
- Sequencer for the CAL calibration-pulse block in the 2D NMR EC FPGA.
- Steps CAL through a programmed sweep of cal_para values. For each step it pulses cal_load, waits a settle time, then holds cal_start for a dwell time.
- Sits between the host register interface and CAL, in the clk_sys domain.

Parameters:
- PARA_W, 6, width of cal_para / base / step values.
- NUM_W, 7, width of step count (0..64).
- TIM_W, 16, width of settle/dwell cycle counters.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seq_start  in  1  single-cycle request to begin a sweep.
- seq_abort  in  1  single-cycle request to stop immediately.
- cfg_para_base  in  PARA_W  first cal_para value.
- cfg_para_step  in  PARA_W  increment per step, modulo 2^PARA_W.
- cfg_num_steps  in  NUM_W  number of steps; 0 means none.
- cfg_settle  in  TIM_W  cycles between cal_load and cal_start.
- cfg_dwell  in  TIM_W  cycles cal_start is held high; 0 is treated as 1.
- cal_load  out  1  one-cycle load strobe to CAL.
- cal_para  out  PARA_W  parameter to CAL; valid while cal_load is high and held afterwards.
- cal_start  out  1  level enable to CAL.
- busy  out  1  high from the cycle after an accepted seq_start until the return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- step_idx  out  NUM_W  index of the current step.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Asserting rst mid-sweep drops cal_start and cal_load asynchronously.
- Output timing: all outputs registered; each output is valid in the same cycle as the state that drives it.
- seq_start handling:
  - Accepted only in IDLE; ignored otherwise.
  - On acceptance, all cfg_* inputs are latched; later cfg changes have no effect until the next start.
- States:
  - IDLE: waits for seq_start.
    - If cfg_num_steps == 0: go to DONE.
    - Otherwise: go to LOAD with step_idx=0 and para=base.
  - LOAD (1 cycle): cal_load=1, cal_para=current para.
    - Go to SETTLE if settle>0, else to DWELL.
  - SETTLE: lasts exactly cfg_settle cycles, then go to DWELL.
  - DWELL: cal_start=1 for exactly max(cfg_dwell,1) cycles.
  - GAP (1 cycle): cal_start=0.
    - If step_idx == num_steps-1: go to DONE.
    - Else: step_idx+1, para = para+step (wraps mod 2^PARA_W), go to LOAD.
  - DONE (1 cycle): done=1, then IDLE.
- Latency:
  - Start sampled at cycle 0 → first cal_load at cycle 1.
  - Step period = 1 + settle + max(dwell,1) + 1 cycles.
- seq_abort:
  - Effective in any non-IDLE state, including DONE.
  - Next cycle: state IDLE, cal_start=0, cal_load=0, busy=0, aborted=1 for one cycle, done not asserted.
  - Ignored in IDLE.
- Simultaneous seq_start and seq_abort in IDLE: abort is ignored, start is accepted.
- Ownership: cal_start and cal_load are never high in the same cycle.
- step_idx holds its last value after completion or abort until the next start.

Optional Feature:
- Macro: CAL_SEQ_LOOP_EN.
- Defined:
  - Adds input port cfg_loop (1 bit), latched at start.
  - When set, GAP after the last step returns to LOAD with step_idx=0 and para=base; done never fires; the sweep runs until seq_abort.
- Undefined: port absent; single-pass sweep only.

Decomposition:
- Package cal_seq_pkg:
  - State enum (IDLE, LOAD, SETTLE, DWELL, GAP, DONE).
  - Default width constants PARA_W, NUM_W, TIM_W.
- Sub-module cal_seq_timer:
  - Loadable TIM_W down-counter with a terminal-count flag.
  - Shared by SETTLE and DWELL.

Test Plan:
- Nominal sweep: base=5, step=3, num=3, settle=2, dwell=4, start at cycle 0 → cal_load at cycles 1, 9, 17 with cal_para 5, 8, 11; cal_start high cycles 4-7, 12-15, 20-23; done at cycle 25; busy low at 26.
- Wrap: base=62, step=1, num=3, settle=0, dwell=1 → cal_para 62, 63, 0; LOAD cycles 1, 4, 7; done at cycle 10.
- Zero steps: num=0 → no cal_load or cal_start; done at cycle 1.
- Abort: nominal config, seq_abort at cycle 13 (step 1 DWELL) → cycle 14 has cal_start=0, aborted=1, busy=0, step_idx=1; no done.
- Start while busy: second seq_start at cycle 5 with base=40 → ignored; sequence identical to the nominal sweep.
- Async reset at cycle 6 → cal_start low immediately, state IDLE; a subsequent start behaves nominally.
- With CAL_SEQ_LOOP_EN and cfg_loop=1: the nominal config repeats; 4th cal_load at cycle 25 with cal_para 5 and no done pulse.

Source files
------------

// File: rtl/cal_seq_pkg.sv
// Shared types and default widths for the CAL calibration sequencer.
package cal_seq_pkg;

  localparam int unsigned PARA_W = 6;   // cal_para / base / step width
  localparam int unsigned NUM_W  = 7;   // step count width (0..64)
  localparam int unsigned TIM_W  = 16;  // settle / dwell counter width

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StDwell,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/cal_seq_ctrl_if.sv
// Host-side control/config and CAL-side drive signals of the sequencer.
// Optional cfg_loop port exists only when CAL_SEQ_LOOP_EN is defined.
interface cal_seq_ctrl_if #(
  parameter int unsigned PARA_W = cal_seq_pkg::PARA_W,
  parameter int unsigned NUM_W  = cal_seq_pkg::NUM_W,
  parameter int unsigned TIM_W  = cal_seq_pkg::TIM_W
);
  logic              seq_start;
  logic              seq_abort;
  logic [PARA_W-1:0] cfg_para_base;
  logic [PARA_W-1:0] cfg_para_step;
  logic [NUM_W-1:0]  cfg_num_steps;
  logic [TIM_W-1:0]  cfg_settle;
  logic [TIM_W-1:0]  cfg_dwell;
`ifdef CAL_SEQ_LOOP_EN
  logic              cfg_loop;
`endif
  logic              cal_load;
  logic [PARA_W-1:0] cal_para;
  logic              cal_start;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [NUM_W-1:0]  step_idx;

  modport master (
`ifdef CAL_SEQ_LOOP_EN
    output cfg_loop,
`endif
    output seq_start, seq_abort, cfg_para_base, cfg_para_step, cfg_num_steps,
    output cfg_settle, cfg_dwell,
    input  cal_load, cal_para, cal_start, busy, done, aborted, step_idx
  );

  modport slave (
`ifdef CAL_SEQ_LOOP_EN
    input  cfg_loop,
`endif
    input  seq_start, seq_abort, cfg_para_base, cfg_para_step, cfg_num_steps,
    input  cfg_settle, cfg_dwell,
    output cal_load, cal_para, cal_start, busy, done, aborted, step_idx
  );
endinterface

// File: rtl/cal_seq_timer.sv
// Loadable down-counter with terminal-count flag, shared by SETTLE and DWELL.
module cal_seq_timer #(
  parameter int unsigned TIM_W = cal_seq_pkg::TIM_W
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TIM_W-1:0] load_val_i,
  output logic             tc_o
);
  logic [TIM_W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIM_W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/cal_seq_ctrl.sv
// CAL calibration sweep sequencer: LOAD -> SETTLE -> DWELL -> GAP per step.
// Optional feature macro: CAL_SEQ_LOOP_EN (adds cfg_loop, endless sweep).
module cal_seq_ctrl #(
  parameter int unsigned PARA_W = cal_seq_pkg::PARA_W,
  parameter int unsigned NUM_W  = cal_seq_pkg::NUM_W,
  parameter int unsigned TIM_W  = cal_seq_pkg::TIM_W
) (
  input logic           clk_sys,
  input logic           rst,
  cal_seq_ctrl_if.slave bus
);
  import cal_seq_pkg::*;

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  idx_q, idx_d;
  logic [PARA_W-1:0] para_q, para_d;
  logic [PARA_W-1:0] step_q;
  logic [NUM_W-1:0]  num_q;
  logic [TIM_W-1:0]  settle_q, dwell_q;
`ifdef CAL_SEQ_LOOP_EN
  logic [PARA_W-1:0] base_q;
  logic              loop_q;
`endif
  logic              latch;
  logic              abort_d;
  logic              tmr_load;
  logic [TIM_W-1:0]  tmr_val;
  logic              tmr_tc;
  logic              cal_load_q, cal_start_q, busy_q, done_q, aborted_q;

  cal_seq_timer #(
    .TIM_W(TIM_W)
  ) u_timer (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Next-state, step datapath and timer load decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    para_d   = para_q;
    latch    = 1'b0;
    abort_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.seq_start) begin
          latch = 1'b1;
          if (bus.cfg_num_steps == '0) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            idx_d   = '0;
            para_d  = bus.cfg_para_base;
          end
        end
      end
      StLoad: begin
        tmr_load = 1'b1;
        if (settle_q != '0) begin
          state_d = StSettle;
          tmr_val = settle_q - TIM_W'(1);
        end else begin
          state_d = StDwell;
          tmr_val = dwell_q - TIM_W'(1);
        end
      end
      StSettle: begin
        if (tmr_tc) begin
          state_d  = StDwell;
          tmr_load = 1'b1;
          tmr_val  = dwell_q - TIM_W'(1);
        end
      end
      StDwell: begin
        if (tmr_tc) state_d = StGap;
      end
      StGap: begin
        if (idx_q == num_q - NUM_W'(1)) begin
`ifdef CAL_SEQ_LOOP_EN
          if (loop_q) begin
            state_d = StLoad;
            idx_d   = '0;
            para_d  = base_q;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StLoad;
          idx_d   = idx_q + NUM_W'(1);
          para_d  = para_q + step_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides everything outside IDLE and freezes step_idx/para.
    if (state_q != StIdle && bus.seq_abort) begin
      state_d = StIdle;
      abort_d = 1'b1;
      idx_d   = idx_q;
      para_d  = para_q;
    end
  end

  // State and step datapath registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      para_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      para_q  <= para_d;
    end
  end

  // Configuration snapshot taken when a start is accepted.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      step_q   <= '0;
      num_q    <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
`ifdef CAL_SEQ_LOOP_EN
      base_q   <= '0;
      loop_q   <= 1'b0;
`endif
    end else if (latch) begin
      step_q   <= bus.cfg_para_step;
      num_q    <= bus.cfg_num_steps;
      settle_q <= bus.cfg_settle;
      dwell_q  <= (bus.cfg_dwell == '0) ? TIM_W'(1) : bus.cfg_dwell;
`ifdef CAL_SEQ_LOOP_EN
      base_q   <= bus.cfg_para_base;
      loop_q   <= bus.cfg_loop;
`endif
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cal_load_q  <= 1'b0;
      cal_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      cal_load_q  <= (state_d == StLoad);
      cal_start_q <= (state_d == StDwell);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      aborted_q   <= abort_d;
    end
  end

  assign bus.cal_load  = cal_load_q;
  assign bus.cal_para  = para_q;
  assign bus.cal_start = cal_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.step_idx  = idx_q;
endmodule

// File: tb/tb_cal_seq_ctrl.sv
// Scoreboard bench for cal_seq_ctrl: expected events are scheduled from the
// sweep rules when a start is issued; a monitor pops and compares them.
module tb_cal_seq_ctrl;
  localparam int unsigned PW = cal_seq_pkg::PARA_W;
  localparam int unsigned NW = cal_seq_pkg::NUM_W;
  localparam int unsigned TW = cal_seq_pkg::TIM_W;

  localparam int K_RUN   = 0;  // cal_start run ended: a=first high cycle, b=length
  localparam int K_LOAD  = 1;  // a=cal_para, b=step_idx
  localparam int K_DONE  = 2;
  localparam int K_ABORT = 3;  // a=step_idx

  localparam int M_NONE   = 0;
  localparam int M_ABORT  = 1;
  localparam int M_BUSY   = 2;
  localparam int M_SIMUL  = 3;
  localparam int M_IDLEAB = 4;

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
  } ev_t;

  logic clk_sys;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   last_idx;
  ev_t  exp_q[$];

  cal_seq_ctrl_if bus ();

  cal_seq_ctrl dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RUN:   return "cal_start_run";
      K_LOAD:  return "cal_load";
      K_DONE:  return "done";
      default: return "aborted";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Insert keeping cycle order; within a cycle the monitor reports run-end,
  // load, done, abort in that order.
  task automatic push_ev(input int kind, input int c, input int a, input int b);
    ev_t e;
    int  pos;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.b    = b;
    pos    = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc * 4 + exp_q[i].kind > c * 4 + kind) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  // Reference schedule: step i loads at t, settles, dwells max(dwell,1), gap.
  // Events at or after cycle 'cut' are dropped; a run crossing it ends there.
  task automatic build(input int s, input int base, input int step, input int num,
                       input int settle, input int dwell, input int cut,
                       output int li, output int done_cyc);
    int d, t, rs, re;
    d  = (dwell == 0) ? 1 : dwell;
    t  = s + 1;
    li = -1;
    for (int i = 0; i < num; i++) begin
      if (t < cut) begin
        push_ev(K_LOAD, t, (base + i * step) % 64, i);
        li = i;
      end
      rs = t + 1 + settle;
      re = rs + d;
      if (rs < cut) begin
        if (re > cut) re = cut;
        push_ev(K_RUN, re, rs, re - rs);
      end
      t = t + 2 + settle + d;
    end
    if (t < cut) push_ev(K_DONE, t, 0, 0);
    done_cyc = t;
  endtask

  task automatic got_ev(input int kind, input int a, input int b);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got cycle=%0d a=%0d b=%0d, required no event",
               kname(kind), cyc, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL event_%s: got cycle=%0d a=%0d b=%0d, required %s cycle=%0d a=%0d b=%0d",
                 kname(kind), cyc, a, b, kname(e.kind), e.cyc, e.a, e.b);
      end
    end
  endtask

  // Monitor: turns DUT outputs into events and checks them against the queue.
  initial begin : monitor
    bit running;
    int rstart;
    running = 1'b0;
    rstart  = 0;
    forever begin
      @(negedge clk_sys);
      if (running && !bus.cal_start) begin
        running = 1'b0;
        got_ev(K_RUN, rstart, cyc - rstart);
      end else if (!running && bus.cal_start) begin
        running = 1'b1;
        rstart  = cyc;
      end
      if (bus.cal_load) got_ev(K_LOAD, int'(bus.cal_para), int'(bus.step_idx));
      if (bus.done) got_ev(K_DONE, 0, 0);
      if (bus.aborted) got_ev(K_ABORT, int'(bus.step_idx), 0);
      if (bus.cal_load && bus.cal_start) begin
        n_tests++;
        n_fail++;
        $display("FAIL ownership: got cal_load=1 cal_start=1 at cycle %0d, required not both", cyc);
      end
    end
  end

  task automatic scramble();
    bus.cfg_para_base = PW'($urandom);
    bus.cfg_para_step = PW'($urandom);
    bus.cfg_num_steps = NW'($urandom);
    bus.cfg_settle    = TW'($urandom);
    bus.cfg_dwell     = TW'($urandom);
  endtask

  task automatic sweep(input int base, input int step, input int num, input int settle,
                       input int dwell, input int mode, input int arg);
    int s, fin, a, cut, li, dcyc, exp_idx;
    if (mode == M_IDLEAB) begin
      bus.seq_abort = 1'b1;
      @(negedge clk_sys);
      bus.seq_abort = 1'b0;
    end
    s = cyc;
    bus.cfg_para_base = PW'(base);
    bus.cfg_para_step = PW'(step);
    bus.cfg_num_steps = NW'(num);
    bus.cfg_settle    = TW'(settle);
    bus.cfg_dwell     = TW'(dwell);
    bus.seq_start     = 1'b1;
    bus.seq_abort     = (mode == M_SIMUL);
    a   = -1;
    cut = 1 << 30;
    if (mode == M_ABORT) begin
      a   = s + arg;
      cut = a + 1;
    end
    build(s, base, step, num, settle, dwell, cut, li, dcyc);
    if (mode == M_ABORT) begin
      exp_idx = (li >= 0) ? li : last_idx;
      push_ev(K_ABORT, a + 1, exp_idx, 0);
      fin = a + 1;
    end else begin
      exp_idx = (num > 0) ? num - 1 : last_idx;
      fin = dcyc;
    end
    @(negedge clk_sys);
    while (cyc < fin + 2) begin
      scramble();
      bus.seq_start = (mode == M_BUSY && cyc == s + arg);
      if (bus.seq_start) bus.cfg_para_base = PW'(40);
      bus.seq_abort = (mode == M_ABORT && cyc == a);
      if (cyc == fin) chk("busy_at_end", int'(bus.busy), (mode == M_ABORT) ? 0 : 1);
      if (cyc == fin + 1) chk("busy_after_end", int'(bus.busy), 0);
      @(negedge clk_sys);
    end
    bus.seq_start = 1'b0;
    bus.seq_abort = 1'b0;
    chk("events_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("step_idx_hold", int'(bus.step_idx), exp_idx);
    last_idx = exp_idx;
  endtask

  task automatic reset_mid_sweep();
    int s, li, dcyc;
    s = cyc;
    bus.cfg_para_base = PW'(5);
    bus.cfg_para_step = PW'(3);
    bus.cfg_num_steps = NW'(3);
    bus.cfg_settle    = TW'(2);
    bus.cfg_dwell     = TW'(4);
    bus.seq_start     = 1'b1;
    build(s, 5, 3, 3, 2, 4, s + 6, li, dcyc);
    @(negedge clk_sys);
    bus.seq_start = 1'b0;
    while (cyc < s + 5) @(negedge clk_sys);
    @(posedge clk_sys);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_cal_start_async", int'(bus.cal_start), 0);
    chk("rst_cal_load_async", int'(bus.cal_load), 0);
    chk("rst_busy_async", int'(bus.busy), 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_step_idx", int'(bus.step_idx), 0);
    chk("events_drained_rst", exp_q.size(), 0);
    exp_q.delete();
    last_idx = 0;
  endtask

  initial begin : driver
    n_tests  = 0;
    n_fail   = 0;
    last_idx = 0;
    rst      = 1'b1;
    bus.seq_start = 1'b0;
    bus.seq_abort = 1'b0;
`ifdef CAL_SEQ_LOOP_EN
    bus.cfg_loop  = 1'b0;
`endif
    scramble();
    repeat (2) @(negedge clk_sys);
    chk("reset_cal_load", int'(bus.cal_load), 0);
    chk("reset_cal_start", int'(bus.cal_start), 0);
    chk("reset_cal_para", int'(bus.cal_para), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_aborted", int'(bus.aborted), 0);
    chk("reset_step_idx", int'(bus.step_idx), 0);
    rst = 1'b0;
    @(negedge clk_sys);

    sweep(5, 3, 3, 2, 4, M_NONE, 0);     // nominal
    sweep(62, 1, 3, 0, 1, M_NONE, 0);    // para wrap
    sweep(9, 9, 0, 3, 3, M_NONE, 0);     // zero steps
    sweep(5, 3, 3, 2, 4, M_ABORT, 13);   // abort in step 1 dwell
    sweep(5, 3, 3, 2, 4, M_BUSY, 5);     // start while busy ignored
    reset_mid_sweep();
    sweep(5, 3, 3, 2, 4, M_NONE, 0);     // nominal after reset
    sweep(7, 2, 2, 1, 0, M_IDLEAB, 0);   // abort in idle ignored, dwell 0 -> 1
    sweep(20, 5, 2, 0, 2, M_SIMUL, 0);   // start+abort in idle: start wins
    sweep(5, 3, 3, 2, 4, M_ABORT, 25);   // abort in DONE

    for (int n = 0; n < 40; n++) begin
      int nm, st, dw, md, rel, ag;
      nm  = $urandom_range(0, 5);
      st  = $urandom_range(0, 5);
      dw  = $urandom_range(0, 5);
      md  = $urandom_range(0, 4);
      rel = 1 + nm * (2 + st + ((dw == 0) ? 1 : dw));
      ag  = $urandom_range(1, rel);
      sweep($urandom_range(0, 63), $urandom_range(0, 63), nm, st, dw, md, ag);
    end

    repeat (5) @(negedge clk_sys);
    chk("final_events_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
